// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter that serializes per-cache coherence messages onto the shared
// coherence data bus, collects snoop responses, then performs memory read or write-back.
module snoop_bus_arbiter #(
    parameter int unsigned NCACHE  = 3,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NCACHE-1:0]        req,
    input  logic [NCACHE*22-1:0]     msg_in,
    input  logic [NCACHE-1:0]        snoop_wb,
    input  logic [NCACHE-1:0]        snoop_abort,
    input  logic [NCACHE*16-1:0]     snoop_data,
    input  logic [15:0]              mem_rdata,
    output logic [NCACHE-1:0]        grant,
    output logic [21:0]              cdb,
    output logic                     cdb_valid,
    output logic [1:0]               cdb_src,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [15:0]              mem_wdata,
    output logic [NCACHE-1:0]        done,
    output logic [15:0]              rdata,
    output logic                     err
);

    localparam int unsigned MSG_W  = 22;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SIT_W  = 6;
    localparam int unsigned IDX_W  = (NCACHE > 1) ? $clog2(NCACHE) : 1;
    localparam int unsigned CNT_W  = $clog2(MEM_LAT + 1);

    localparam logic [SIT_W-1:0] SIT_WR_MISS = 6'b000000;
    localparam logic [SIT_W-1:0] SIT_RD_MISS = 6'b000001;
    localparam logic [SIT_W-1:0] SIT_INVAL   = 6'b000100;

    typedef struct packed {
        logic [SIT_W-1:0]  situation;
        logic [DATA_W-1:0] data;
    } msg_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BCAST,
        S_SNOOP,
        S_MEMRD,
        S_WB,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    msg_t              msg_q, msg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    msg_t              msg_arr  [NCACHE];
    logic [DATA_W-1:0] data_arr [NCACHE];

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic              resp_found;
    logic [IDX_W-1:0]  resp_idx;
    logic [NCACHE-1:0] resp_mask;
    logic              is_miss;
    int                cand;
    logic [IDX_W-1:0]  cand_idx;

    for (genvar g = 0; g < int'(NCACHE); g++) begin : g_unpack
        assign msg_arr[g]  = msg_in[MSG_W*g +: MSG_W];
        assign data_arr[g] = snoop_data[DATA_W*g +: DATA_W];
    end

    function automatic logic [NCACHE-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot = NCACHE'(1) << i;
    endfunction

    function automatic logic legal_code(input logic [SIT_W-1:0] s);
        legal_code = (s == SIT_WR_MISS) || (s == SIT_RD_MISS) || (s == SIT_INVAL);
    endfunction

    assign is_miss = (msg_q.situation == SIT_WR_MISS) || (msg_q.situation == SIT_RD_MISS);

    // Next-state, datapath capture and arbitration
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        msg_d      = msg_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;
        win_found  = 1'b0;
        win_idx    = '0;
        resp_found = 1'b0;
        resp_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        resp_mask  = (snoop_wb | snoop_abort) & ~onehot(idx_q);

        // Search starts one past the last winner and wraps
        for (int k = 1; k <= int'(NCACHE); k++) begin
            cand = int'(last_q) + k;
            if (cand >= int'(NCACHE)) begin
                cand = cand - int'(NCACHE);
            end
            cand_idx = IDX_W'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end

        // Lowest-index non-source responder supplies the write-back data
        for (int i = 0; i < int'(NCACHE); i++) begin
            if (!resp_found && resp_mask[i]) begin
                resp_found = 1'b1;
                resp_idx   = IDX_W'(i);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    msg_d   = msg_arr[win_idx];
                    data_d  = '0;
                    cnt_d   = '0;
                    err_d   = !legal_code(msg_arr[win_idx].situation);
                    state_d = legal_code(msg_arr[win_idx].situation) ? S_BCAST : S_DONE;
                end
            end
            S_BCAST: begin
                state_d = S_SNOOP;
            end
            S_SNOOP: begin
                if (resp_found) begin
                    data_d  = data_arr[resp_idx];
                    state_d = S_WB;
                end else if (is_miss) begin
                    cnt_d   = '0;
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_MEMRD: begin
                if (cnt_q == CNT_W'(MEM_LAT)) begin
                    data_d  = mem_rdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                last_d  = idx_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; outputs are registered from the next-state decode
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            last_q    <= IDX_W'(NCACHE - 1);
            msg_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            grant     <= '0;
            cdb       <= '0;
            cdb_valid <= 1'b0;
            cdb_src   <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            done      <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            msg_q     <= msg_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            err_q     <= err_d;
            grant     <= (state_d != S_IDLE) ? onehot(idx_d) : '0;
            cdb       <= (state_d == S_BCAST) ? msg_d : '0;
            cdb_valid <= (state_d == S_BCAST);
            cdb_src   <= (state_d == S_BCAST) ? 2'(idx_d) : 2'b00;
            mem_re    <= (state_d == S_MEMRD) && (state_q != S_MEMRD);
            mem_we    <= (state_d == S_WB);
            mem_wdata <= (state_d == S_WB) ? data_d : '0;
            done      <= (state_d == S_DONE) ? onehot(idx_d) : '0;
            // Invalidates never return data, even if a snooper wrote back
            rdata     <= ((state_d == S_DONE) && (msg_d.situation != SIT_INVAL)) ? data_d : '0;
            err       <= (state_d == S_DONE) && err_d;
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: reset, invalidate, memory read, write-back,
// round-robin, source masking, illegal code and reset mid-transaction.
module tb_snoop_bus_arbiter;

    localparam int unsigned NC = 3;

    logic            clock;
    logic            reset;
    logic [NC-1:0]   req;
    logic [NC*22-1:0] msg_in;
    logic [NC-1:0]   snoop_wb;
    logic [NC-1:0]   snoop_abort;
    logic [NC*16-1:0] snoop_data;
    logic [15:0]     mem_rdata;
    logic [NC-1:0]   grant;
    logic [21:0]     cdb;
    logic            cdb_valid;
    logic [1:0]      cdb_src;
    logic            mem_re;
    logic            mem_we;
    logic [15:0]     mem_wdata;
    logic [NC-1:0]   done;
    logic [15:0]     rdata;
    logic            err;

    int checks = 0;
    int failures = 0;

    snoop_bus_arbiter #(.NCACHE(NC), .MEM_LAT(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .msg_in      (msg_in),
        .snoop_wb    (snoop_wb),
        .snoop_abort (snoop_abort),
        .snoop_data  (snoop_data),
        .mem_rdata   (mem_rdata),
        .grant       (grant),
        .cdb         (cdb),
        .cdb_valid   (cdb_valid),
        .cdb_src     (cdb_src),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .done        (done),
        .rdata       (rdata),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_msg(input int i, input logic [5:0] sit, input logic [15:0] d);
        msg_in[22*i +: 22] = {sit, d};
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        checks++; if (grant !== 3'b000) begin failures++; $display("FAIL rst_grant: got %b expected %b", grant, 3'b000); end
        checks++; if (cdb_valid !== 1'b0 || cdb !== 22'h0) begin failures++; $display("FAIL rst_cdb: got valid=%b cdb=%h expected 0/0", cdb_valid, cdb); end
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem: got re=%b we=%b expected 0/0", mem_re, mem_we); end
        checks++; if (done !== 3'b000 || rdata !== 16'h0 || err !== 1'b0) begin failures++; $display("FAIL rst_done: got done=%b rdata=%h err=%b expected 0", done, rdata, err); end
    endtask

    task automatic test_invalidate;
        set_msg(0, 6'b000100, 16'h0000);
        req = 3'b001;
        tick;
        checks++; if (grant !== 3'b001) begin failures++; $display("FAIL inv_grant: got %b expected %b", grant, 3'b001); end
        checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL inv_cdb_valid: got %b expected 1", cdb_valid); end
        checks++; if (cdb !== {6'b000100, 16'h0000}) begin failures++; $display("FAIL inv_cdb: got %h expected %h", cdb, {6'b000100, 16'h0000}); end
        checks++; if (cdb_src !== 2'd0) begin failures++; $display("FAIL inv_src: got %0d expected 0", cdb_src); end
        tick;
        checks++; if (cdb_valid !== 1'b0 || done !== 3'b000) begin failures++; $display("FAIL inv_snoop: got valid=%b done=%b expected 0/000", cdb_valid, done); end
        tick;
        checks++; if (done !== 3'b001) begin failures++; $display("FAIL inv_done: got %b expected %b", done, 3'b001); end
        checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL inv_rdata: got %h expected 0000", rdata); end
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL inv_mem: got re=%b we=%b expected 0/0", mem_re, mem_we); end
        req = 3'b000;
        tick;
        checks++; if (done !== 3'b000 || grant !== 3'b000) begin failures++; $display("FAIL inv_after: got done=%b grant=%b expected 000/000", done, grant); end
    endtask

    task automatic test_mem_read;
        set_msg(1, 6'b000001, 16'h0000);
        mem_rdata = 16'hDEAD;
        req = 3'b010;
        tick;
        checks++; if (grant !== 3'b010 || cdb_valid !== 1'b1 || cdb_src !== 2'd1) begin failures++; $display("FAIL mrd_bcast: got grant=%b valid=%b src=%0d expected 010/1/1", grant, cdb_valid, cdb_src); end
        checks++; if (cdb !== {6'b000001, 16'h0000}) begin failures++; $display("FAIL mrd_cdb: got %h expected %h", cdb, {6'b000001, 16'h0000}); end
        tick;
        checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL mrd_re_early: got %b expected 0", mem_re); end
        tick;
        checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL mrd_re: got re=%b we=%b expected 1/0", mem_re, mem_we); end
        tick;
        checks++; if (mem_re !== 1'b0 || done !== 3'b000) begin failures++; $display("FAIL mrd_re_pulse: got re=%b done=%b expected 0/000", mem_re, done); end
        tick;
        checks++; if (done !== 3'b000) begin failures++; $display("FAIL mrd_done_early: got %b expected 000", done); end
        mem_rdata = 16'hBEEF;
        tick;
        checks++; if (done !== 3'b010) begin failures++; $display("FAIL mrd_done: got %b expected %b", done, 3'b010); end
        checks++; if (rdata !== 16'hBEEF || err !== 1'b0) begin failures++; $display("FAIL mrd_rdata: got %h err=%b expected beef/0", rdata, err); end
        req = 3'b000;
        mem_rdata = 16'h0000;
        tick;
        checks++; if (done !== 3'b000 || rdata !== 16'h0) begin failures++; $display("FAIL mrd_after: got done=%b rdata=%h expected 000/0000", done, rdata); end
    endtask

    task automatic test_writeback;
        set_msg(0, 6'b000000, 16'h0000);
        req = 3'b001;
        tick;
        checks++; if (grant !== 3'b001 || cdb_valid !== 1'b1) begin failures++; $display("FAIL wb_bcast: got grant=%b valid=%b expected 001/1", grant, cdb_valid); end
        tick;
        snoop_wb = 3'b100;
        snoop_abort = 3'b100;
        snoop_data[2*16 +: 16] = 16'h1234;
        tick;
        snoop_wb = 3'b000;
        snoop_abort = 3'b000;
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 16'h1234) begin failures++; $display("FAIL wb_write: got we=%b wdata=%h expected 1/1234", mem_we, mem_wdata); end
        checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL wb_no_re: got %b expected 0", mem_re); end
        tick;
        checks++; if (done !== 3'b001 || rdata !== 16'h1234) begin failures++; $display("FAIL wb_done: got done=%b rdata=%h expected 001/1234", done, rdata); end
        checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin failures++; $display("FAIL wb_mem_after: got re=%b we=%b expected 0/0", mem_re, mem_we); end
        req = 3'b000;
        snoop_data = '0;
        tick;
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_grant [4];
        exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_msg(c, 6'b000100, 16'h0000);
        end
        req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            tick;
            checks++; if (cdb_valid !== 1'b1 || grant !== exp_grant[n]) begin failures++; $display("FAIL rr_grant%0d: got grant=%b valid=%b expected %b/1", n, grant, cdb_valid, exp_grant[n]); end
            tick;
            tick;
            checks++; if (done !== exp_grant[n]) begin failures++; $display("FAIL rr_done%0d: got %b expected %b", n, done, exp_grant[n]); end
            if (n == 3) req = 3'b000;
            tick;
            checks++; if (grant !== 3'b000 || cdb_valid !== 1'b0) begin failures++; $display("FAIL rr_idle%0d: got grant=%b valid=%b expected 000/0", n, grant, cdb_valid); end
        end
    endtask

    task automatic test_mask_and_illegal;
        set_msg(0, 6'b000001, 16'h0000);
        snoop_wb = 3'b001;
        snoop_abort = 3'b001;
        snoop_data[0 +: 16] = 16'h5555;
        mem_rdata = 16'h7777;
        req = 3'b001;
        tick;
        checks++; if (grant !== 3'b001) begin failures++; $display("FAIL mask_grant: got %b expected 001", grant); end
        tick;
        tick;
        checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL mask_path: got re=%b we=%b expected 1/0", mem_re, mem_we); end
        tick;
        tick;
        tick;
        checks++; if (done !== 3'b001 || rdata !== 16'h7777) begin failures++; $display("FAIL mask_done: got done=%b rdata=%h expected 001/7777", done, rdata); end
        req = 3'b000;
        snoop_wb = 3'b000;
        snoop_abort = 3'b000;
        snoop_data = '0;
        mem_rdata = 16'h0000;
        tick;
        set_msg(1, 6'b111111, 16'hABCD);
        req = 3'b010;
        tick;
        checks++; if (cdb_valid !== 1'b0 || cdb !== 22'h0) begin failures++; $display("FAIL ill_bcast: got valid=%b cdb=%h expected 0/0", cdb_valid, cdb); end
        checks++; if (done !== 3'b010 || err !== 1'b1 || rdata !== 16'h0) begin failures++; $display("FAIL ill_done: got done=%b err=%b rdata=%h expected 010/1/0000", done, err, rdata); end
        req = 3'b000;
        tick;
        checks++; if (done !== 3'b000 || err !== 1'b0) begin failures++; $display("FAIL ill_after: got done=%b err=%b expected 000/0", done, err); end
    endtask

    task automatic test_reset_mid;
        set_msg(2, 6'b000001, 16'h0000);
        req = 3'b100;
        tick;
        checks++; if (grant !== 3'b100) begin failures++; $display("FAIL rmid_grant: got %b expected 100", grant); end
        tick;
        tick;
        checks++; if (mem_re !== 1'b1) begin failures++; $display("FAIL rmid_re: got %b expected 1", mem_re); end
        reset = 1'b1;
        req = 3'b000;
        tick;
        reset = 1'b0;
        checks++; if (grant !== 3'b000 || mem_re !== 1'b0 || mem_we !== 1'b0 || cdb_valid !== 1'b0 || done !== 3'b000) begin failures++; $display("FAIL rmid_clear: got grant=%b re=%b we=%b valid=%b done=%b expected all 0", grant, mem_re, mem_we, cdb_valid, done); end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (done !== 3'b000) begin failures++; $display("FAIL rmid_nodone%0d: got %b expected 000", i, done); end
        end
        set_msg(0, 6'b000100, 16'h0000);
        set_msg(1, 6'b000100, 16'h0000);
        req = 3'b011;
        tick;
        checks++; if (grant !== 3'b001) begin failures++; $display("FAIL rmid_regrant: got %b expected 001", grant); end
        req = 3'b000;
        tick;
        tick;
        tick;
    endtask

    initial begin
        reset = 1'b0;
        req = '0;
        msg_in = '0;
        snoop_wb = '0;
        snoop_abort = '0;
        snoop_data = '0;
        mem_rdata = '0;
        test_reset;
        test_invalidate;
        test_mem_read;
        test_writeback;
        test_round_robin;
        test_mask_and_illegal;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
